wb_timeout_bridge: RTL and testbench

- Registered WISHBONE (classic, non-pipelined) bridge placed directly upstream of a target such as the bus-terminating dummy slave or a real register slave.
- Latches each master request, forwards it to the downstream target, and returns the target's termination registered by one cycle.
- If the target does not terminate within TIMEOUT cycles, the bridge ends the cycle itself with an error, so an unresponsive or unpopulated target never hangs the bus.

---
 rtl/wb_timeout_bridge_pkg.sv | 21 ++
 rtl/wb_timeout_ctr.sv | 28 ++
 rtl/wb_timeout_bridge.sv | 141 ++++++++++++++
 tb/tb_wb_timeout_bridge.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_timeout_bridge_pkg.sv
// rtl/wb_timeout_bridge_pkg.sv - shared encodings and counter sizing for the WISHBONE timeout bridge
package wb_timeout_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        TERM_ACK = 2'd0,
        TERM_ERR = 2'd1,
        TERM_RTY = 2'd2
    } term_e;

    // Wide enough to hold TIMEOUT itself so the counter can saturate without wrapping.
    function automatic int ctr_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// rtl/wb_timeout_ctr.sv - saturating wait-cycle counter with terminal count at TIMEOUT-1
module wb_timeout_ctr #(
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_TC  = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt <= '0;
        end else if (en_i && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc_o = (cnt == CNT_TC);

endmodule

// File: rtl/wb_timeout_bridge.sv
// rtl/wb_timeout_bridge.sv - registered WISHBONE bridge with forced error on timeout; optional WB_TIMEOUT_BRIDGE_CAPTURE_EN
module wb_timeout_bridge
    import wb_timeout_bridge_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT       = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      s_cyc_i,
    input  logic                      s_stb_i,
    input  logic                      s_we_i,
    input  logic [ADDRESS_WIDTH-1:0]  s_adr_i,
    input  logic [DATA_WIDTH-1:0]     s_dat_i,
    input  logic [DATA_WIDTH/8-1:0]   s_sel_i,
    output logic                      s_ack_o,
    output logic                      s_err_o,
    output logic                      s_rty_o,
    output logic [DATA_WIDTH-1:0]     s_dat_o,
    output logic                      m_cyc_o,
    output logic                      m_stb_o,
    output logic                      m_we_o,
    output logic [ADDRESS_WIDTH-1:0]  m_adr_o,
    output logic [DATA_WIDTH-1:0]     m_dat_o,
    output logic [DATA_WIDTH/8-1:0]   m_sel_o,
    input  logic                      m_ack_i,
    input  logic                      m_err_i,
    input  logic                      m_rty_i,
    input  logic [DATA_WIDTH-1:0]     m_dat_i,
    output logic                      timeout_o
`ifdef WB_TIMEOUT_BRIDGE_CAPTURE_EN
    ,
    output logic [ADDRESS_WIDTH-1:0]  to_adr_o,
    output logic [15:0]               to_cnt_o
`endif
);

    localparam int CW = ctr_width(TIMEOUT);

    state_e state;
    term_e  term_sel;
    logic   term_hit;
    logic   tc;

    wb_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_ctr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (state != REQ),
        .en_i  (state == REQ),
        .tc_o  (tc)
    );

    always_comb begin
        term_hit = m_err_i | m_rty_i | m_ack_i;
        term_sel = TERM_ACK;
        if (m_err_i) begin
            term_sel = TERM_ERR;
        end else if (m_rty_i) begin
            term_sel = TERM_RTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            s_ack_o   <= 1'b0;
            s_err_o   <= 1'b0;
            s_rty_o   <= 1'b0;
            s_dat_o   <= '0;
            m_cyc_o   <= 1'b0;
            m_stb_o   <= 1'b0;
            m_we_o    <= 1'b0;
            m_adr_o   <= '0;
            m_dat_o   <= '0;
            m_sel_o   <= '0;
            timeout_o <= 1'b0;
`ifdef WB_TIMEOUT_BRIDGE_CAPTURE_EN
            to_adr_o  <= '0;
            to_cnt_o  <= '0;
`endif
        end else begin
            s_ack_o   <= 1'b0;
            s_err_o   <= 1'b0;
            s_rty_o   <= 1'b0;
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_cyc_i && s_stb_i) begin
                        m_we_o  <= s_we_i;
                        m_adr_o <= s_adr_i;
                        m_dat_o <= s_dat_i;
                        m_sel_o <= s_sel_i;
                        m_cyc_o <= 1'b1;
                        m_stb_o <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    // A master abort beats everything and leaves the upstream unterminated.
                    if (!s_cyc_i) begin
                        m_cyc_o <= 1'b0;
                        m_stb_o <= 1'b0;
                        state   <= IDLE;
                    end else if (term_hit) begin
                        m_cyc_o <= 1'b0;
                        m_stb_o <= 1'b0;
                        s_dat_o <= (term_sel == TERM_ACK) ? m_dat_i : '0;
                        s_ack_o <= (term_sel == TERM_ACK);
                        s_err_o <= (term_sel == TERM_ERR);
                        s_rty_o <= (term_sel == TERM_RTY);
                        state   <= RESP;
                    end else if (tc) begin
                        m_cyc_o   <= 1'b0;
                        m_stb_o   <= 1'b0;
                        s_dat_o   <= '0;
                        s_err_o   <= 1'b1;
                        timeout_o <= 1'b1;
                        state     <= RESP;
`ifdef WB_TIMEOUT_BRIDGE_CAPTURE_EN
                        to_adr_o  <= m_adr_o;
                        if (to_cnt_o != 16'hFFFF) begin
                            to_cnt_o <= to_cnt_o + 16'd1;
                        end
`endif
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// tb/tb_wb_timeout_bridge.sv - self-checking bench for wb_timeout_bridge with a cycle-timeline model
module tb_wb_timeout_bridge;

    localparam int TO = 8;
    localparam int NC = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_cyc_i, s_stb_i, s_we_i;
    logic [15:0] s_adr_i;
    logic [31:0] s_dat_i;
    logic [3:0]  s_sel_i;
    logic        s_ack_o, s_err_o, s_rty_o;
    logic [31:0] s_dat_o;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [15:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [3:0]  m_sel_o;
    logic        m_ack_i, m_err_i, m_rty_i;
    logic [31:0] m_dat_i;
    logic        timeout_o;
    logic        dummy_mode;
    logic        sched_ack;
`ifdef WB_TIMEOUT_BRIDGE_CAPTURE_EN
    logic [15:0] to_adr_o;
    logic [15:0] to_cnt_o;
`endif

    always #5 clk = ~clk;

    assign m_ack_i = dummy_mode ? (m_cyc_o & m_stb_o) : sched_ack;

    wb_timeout_bridge #(
        .ADDRESS_WIDTH (16),
        .DATA_WIDTH    (32),
        .TIMEOUT       (TO)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .s_cyc_i   (s_cyc_i),
        .s_stb_i   (s_stb_i),
        .s_we_i    (s_we_i),
        .s_adr_i   (s_adr_i),
        .s_dat_i   (s_dat_i),
        .s_sel_i   (s_sel_i),
        .s_ack_o   (s_ack_o),
        .s_err_o   (s_err_o),
        .s_rty_o   (s_rty_o),
        .s_dat_o   (s_dat_o),
        .m_cyc_o   (m_cyc_o),
        .m_stb_o   (m_stb_o),
        .m_we_o    (m_we_o),
        .m_adr_o   (m_adr_o),
        .m_dat_o   (m_dat_o),
        .m_sel_o   (m_sel_o),
        .m_ack_i   (m_ack_i),
        .m_err_i   (m_err_i),
        .m_rty_i   (m_rty_i),
        .m_dat_i   (m_dat_i),
        .timeout_o (timeout_o)
`ifdef WB_TIMEOUT_BRIDGE_CAPTURE_EN
        ,
        .to_adr_o  (to_adr_o),
        .to_cnt_o  (to_cnt_o)
`endif
    );

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Expected behaviour laid out on an absolute cycle timeline.
    bit          exp_req [NC];
    bit          exp_ack [NC];
    bit          exp_err [NC];
    bit          exp_rty [NC];
    bit          exp_to  [NC];
    bit          exp_we  [NC];
    logic [15:0] exp_adr [NC];
    logic [31:0] exp_dat [NC];
    logic [3:0]  exp_sel [NC];
    logic [31:0] exp_sdat[NC];

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;
    int stb_cnt, ack_cnt, err_cnt, rty_cnt, to_pulses, ack_cyc, err_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc_n, act, want);
        end
    endtask

    task automatic clr_mon();
        stb_cnt = 0; ack_cnt = 0; err_cnt = 0; rty_cnt = 0; to_pulses = 0;
        ack_cyc = -1; err_cyc = -1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            if (cyc_n >= NC) begin
                chk("cycle_budget", 64'(cyc_n), 64'(NC - 1));
            end else begin
                chk("m_cyc", m_cyc_o, exp_req[cyc_n]);
                chk("m_stb", m_stb_o, exp_req[cyc_n]);
                chk("s_ack", s_ack_o, exp_ack[cyc_n]);
                chk("s_err", s_err_o, exp_err[cyc_n]);
                chk("s_rty", s_rty_o, exp_rty[cyc_n]);
                chk("timeout", timeout_o, exp_to[cyc_n]);
                if (exp_req[cyc_n]) begin
                    chk("m_we", m_we_o, exp_we[cyc_n]);
                    chk("m_adr", m_adr_o, exp_adr[cyc_n]);
                    chk("m_dat", m_dat_o, exp_dat[cyc_n]);
                    chk("m_sel", m_sel_o, exp_sel[cyc_n]);
                end
                if (exp_ack[cyc_n] || exp_err[cyc_n] || exp_rty[cyc_n]) begin
                    chk("s_dat", s_dat_o, exp_sdat[cyc_n]);
                end
            end
            stb_cnt += int'(m_stb_o);
            rty_cnt += int'(s_rty_o);
            to_pulses += int'(timeout_o);
            if (s_ack_o) begin
                ack_cnt++;
                if (ack_cyc < 0) ack_cyc = cyc_n;
            end
            if (s_err_o) begin
                err_cnt++;
                if (err_cyc < 0) err_cyc = cyc_n;
            end
        end
    end

    // wait_k: request-cycle index at which the target terminates (-1 = never);
    // abort_k / rst_k: request-cycle index at which s_cyc_i drops / rst_i pulses.
    task automatic txn(input bit we, input logic [15:0] adr, input logic [31:0] wdat,
                       input logic [3:0] sel, input int wait_k, input bit ta, input bit te,
                       input bit tr, input logic [31:0] rdat, input int abort_k, input int rst_k);
        int n, endi, r;
        bit resp_ok, cut;
        n = cyc_n;
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we;
        s_adr_i = adr; s_dat_i = wdat; s_sel_i = sel; m_dat_i = rdat;
        cut     = (abort_k >= 0) || (rst_k >= 0);
        resp_ok = (wait_k >= 0) && (wait_k <= TO - 1) && (ta || te || tr);
        if (cut) endi = (abort_k >= 0) ? abort_k : rst_k;
        else     endi = resp_ok ? wait_k : TO - 1;
        for (int i = n + 1; i <= n + 1 + endi; i++) begin
            exp_req[i] = 1'b1; exp_we[i] = we; exp_adr[i] = adr;
            exp_dat[i] = wdat; exp_sel[i] = sel;
        end
        r = n + 2 + endi;
        if (!cut) begin
            if (!resp_ok) begin
                exp_err[r] = 1'b1;
                exp_to[r]  = 1'b1;
            end else if (te) exp_err[r] = 1'b1;
            else if (tr)     exp_rty[r] = 1'b1;
            else             exp_ack[r] = 1'b1;
            exp_sdat[r] = (resp_ok && !te && !tr) ? rdat : 32'h0;
        end
        for (int k = 0; k <= endi + 1; k++) begin
            @(posedge clk); #1;
            sched_ack = (k == wait_k) && ta;
            m_err_i   = (k == wait_k) && te;
            m_rty_i   = (k == wait_k) && tr;
            if (k == abort_k) begin
                s_cyc_i = 1'b0; s_stb_i = 1'b0;
            end
            if (k == rst_k) begin
                rst = 1'b1; s_cyc_i = 1'b0; s_stb_i = 1'b0;
            end
            if (k == rst_k + 1) rst = 1'b0;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
    endtask

    initial begin
        #40000;
        $display("FAIL watchdog cycle=%0d", cyc_n);
        $fatal(1);
    end

    initial begin
        int n0;
        rst = 1'b1; dummy_mode = 1'b0; sched_ack = 1'b0;
        s_cyc_i = 0; s_stb_i = 0; s_we_i = 0; s_adr_i = 0; s_dat_i = 0; s_sel_i = 0;
        m_err_i = 0; m_rty_i = 0; m_dat_i = 0;
        clr_mon();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_m_cyc", m_cyc_o, 1'b0);
        chk("rst_s_ack", s_ack_o | s_err_o | s_rty_o | timeout_o, 1'b0);
        chk("rst_m_adr", m_adr_o, 16'h0);
        chk("rst_s_dat", s_dat_o, 32'h0);
        chk_on = 1'b1;
        @(posedge clk); #1;

        // dummy-slave read
        dummy_mode = 1'b1; clr_mon(); n0 = cyc_n;
        txn(1'b0, 16'h1234, 32'h0, 4'hF, 0, 1'b1, 1'b0, 1'b0, 32'h0, -1, -1);
        dummy_mode = 1'b0;
        chk("dummy_stb_cycles", 64'(stb_cnt), 64'd1);
        chk("dummy_ack_pulses", 64'(ack_cnt), 64'd1);
        chk("dummy_ack_latency", 64'(ack_cyc - n0), 64'd2);
        chk("dummy_no_timeout", 64'(to_pulses), 64'd0);

        // unresponsive target
        clr_mon(); n0 = cyc_n;
        txn(1'b0, 16'h00A0, 32'h0, 4'hF, -1, 1'b0, 1'b0, 1'b0, 32'h0, -1, -1);
        chk("to_stb_cycles", 64'(stb_cnt), 64'd8);
        chk("to_err_pulses", 64'(err_cnt), 64'd1);
        chk("to_pulses", 64'(to_pulses), 64'd1);
        chk("to_err_latency", 64'(err_cyc - n0), 64'd9);
`ifdef WB_TIMEOUT_BRIDGE_CAPTURE_EN
        chk("to_adr", to_adr_o, 16'h00A0);
        chk("to_cnt", to_cnt_o, 16'd1);
`endif

        // err and ack together on the 3rd wait cycle
        clr_mon();
        txn(1'b0, 16'h0200, 32'h0, 4'hF, 2, 1'b1, 1'b1, 1'b0, 32'h12345678, -1, -1);
        chk("errack_err", 64'(err_cnt), 64'd1);
        chk("errack_ack", 64'(ack_cnt), 64'd0);

        // lone retry
        clr_mon();
        txn(1'b1, 16'h0300, 32'hA5A5A5A5, 4'h1, 1, 1'b0, 1'b0, 1'b1, 32'h0, -1, -1);
        chk("rty_pulses", 64'(rty_cnt), 64'd1);
        chk("rty_no_err", 64'(err_cnt), 64'd0);

        // ack exactly at terminal count
        clr_mon();
        txn(1'b0, 16'h0400, 32'h0, 4'hF, TO - 1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, -1, -1);
        chk("tc_ack", 64'(ack_cnt), 64'd1);
        chk("tc_no_err", 64'(err_cnt), 64'd0);
        chk("tc_no_timeout", 64'(to_pulses), 64'd0);
        chk("tc_rdata", s_dat_o, 32'hDEADBEEF);

        // plain read
        txn(1'b0, 16'h0500, 32'h0, 4'hC, 3, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D, -1, -1);

        // master abort, then reset mid-request
        clr_mon();
        txn(1'b0, 16'h0600, 32'h0, 4'hF, -1, 1'b0, 1'b0, 1'b0, 32'h0, 2, -1);
        txn(1'b1, 16'h0700, 32'h77777777, 4'hF, -1, 1'b0, 1'b0, 1'b0, 32'h0, -1, 1);
        chk("cut_no_term", 64'(ack_cnt + err_cnt + rty_cnt), 64'd0);
        chk("cut_m_adr", m_adr_o, 16'h0);
        chk("cut_m_dat", m_dat_o, 32'h0);
        chk("cut_m_sel", m_sel_o, 4'h0);
        chk("cut_s_dat", s_dat_o, 32'h0);

        // back-to-back writes
        clr_mon();
        txn(1'b1, 16'h0010, 32'h11223344, 4'hF, 1, 1'b1, 1'b0, 1'b0, 32'h0, -1, -1);
        txn(1'b1, 16'h0014, 32'h00005566, 4'h3, 1, 1'b1, 1'b0, 1'b0, 32'h0, -1, -1);
        chk("b2b_acks", 64'(ack_cnt), 64'd2);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
